// File: rtl/rv_bus_pkg.sv
// Shared Wishbone arbiter types: request bundle, FSM states and timeout defaults.
package rv_bus_pkg;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
  } wb_req_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_TIMEOUT_DEFAULT = 255;
  localparam int TMO_W               = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first requester after i_last (mod N).
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_vld,
  output logic [IW-1:0] o_idx,
  output logic [N-1:0]  o_onehot
);

  logic [IW-1:0] cand;

  always_comb begin
    o_vld    = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    cand     = '0;
    // Walk from farthest to nearest so the nearest requester overwrites the rest.
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(i_last) + k) % N);
      if (i_req[cand]) begin
        o_vld = 1'b1;
        o_idx = cand;
      end
    end
    o_onehot[o_idx] = o_vld;
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone master arbiter; grant held per CYC burst, 1-cycle grant latency.
// Optional STB-without-ACK watchdog enabled by WB_ARB_TIMEOUT_EN.
module wb_master_arbiter
  import rv_bus_pkg::*;
#(
  parameter int MASTERS        = 2,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [MASTERS-1:0][31:0] i_m_adr,
  input  logic [MASTERS-1:0][31:0] i_m_dat,
  input  logic [MASTERS-1:0]       i_m_we,
  input  logic [MASTERS-1:0][3:0]  i_m_sel,
  input  logic [MASTERS-1:0]       i_m_stb,
  input  logic [MASTERS-1:0]       i_m_cyc,
  output logic [31:0]              o_m_dat,
  output logic [MASTERS-1:0]       o_m_ack,
  output logic [MASTERS-1:0]       o_m_err,
  output logic [31:0]              o_wb_adr,
  output logic [31:0]              o_wb_dat,
  output logic                     o_wb_we,
  output logic [3:0]               o_wb_sel,
  output logic                     o_wb_stb,
  output logic                     o_wb_cyc,
  input  logic [31:0]              i_wb_dat,
  input  logic                     i_wb_ack,
  output logic [MASTERS-1:0]       o_grant
);

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  if (MASTERS < 2 || MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wb_master_arbiter: unsupported MASTERS or TIMEOUT_CYCLES");
  end

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [MASTERS-1:0] req;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [MASTERS-1:0] pick_onehot;
  logic          tmo_fire;
  wb_req_t       bus_req;

  rr_pick #(.N(MASTERS), .IW(IW)) u_pick (
    .i_req    (req),
    .i_last   (last_q),
    .o_vld    (pick_vld),
    .o_idx    (pick_idx),
    .o_onehot (pick_onehot)
  );

`ifdef WB_ARB_TIMEOUT_EN
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [MASTERS-1:0] lock_q, lock_d;

  // A timed-out owner stays locked out until it lets go of CYC.
  assign req = i_m_cyc & ~lock_q;

  always_comb begin
    tmo_fire = (state_q == ARB_BUSY) && i_m_stb[grant_q] && !i_wb_ack &&
               (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    cnt_d = '0;
    if (state_q == ARB_BUSY && i_m_stb[grant_q] && !i_wb_ack) cnt_d = cnt_q + TMO_W'(1);
    lock_d = lock_q;
    if (tmo_fire) lock_d[grant_q] = 1'b1;
    lock_d = lock_d & i_m_cyc;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q  <= '0;
      lock_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end
`else
  assign req      = i_m_cyc;
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d = ARB_BUSY;
          grant_d = pick_idx;
          last_d  = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (!i_m_cyc[grant_q] || tmo_fire) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus_req = '0;
    o_grant = '0;
    o_m_ack = '0;
    if (state_q == ARB_BUSY) begin
      bus_req.adr = i_m_adr[grant_q];
      bus_req.dat = i_m_dat[grant_q];
      bus_req.we  = i_m_we[grant_q];
      bus_req.sel = i_m_sel[grant_q];
      bus_req.stb = i_m_stb[grant_q];
      bus_req.cyc = i_m_cyc[grant_q];
      o_grant[grant_q] = 1'b1;
      o_m_ack[grant_q] = i_wb_ack;
    end
  end

  assign o_m_err  = tmo_fire ? o_grant : '0;
  assign o_m_dat  = i_wb_dat;
  assign o_wb_adr = bus_req.adr;
  assign o_wb_dat = bus_req.dat;
  assign o_wb_we  = bus_req.we;
  assign o_wb_sel = bus_req.sel;
  assign o_wb_stb = bus_req.stb;
  assign o_wb_cyc = bus_req.cyc;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IW'(MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_wb_master_arbiter;

  localparam int M = 3;
  localparam int T = 16;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [M-1:0][31:0] m_adr, m_dat;
  logic [M-1:0]      m_we, m_stb, m_cyc;
  logic [M-1:0][3:0] m_sel;
  logic [31:0]       o_m_dat;
  logic [M-1:0]      o_m_ack, o_m_err, o_grant;
  logic [31:0]       o_wb_adr, o_wb_dat;
  logic              o_wb_we, o_wb_stb, o_wb_cyc;
  logic [3:0]        o_wb_sel;
  logic [31:0]       wb_dat;
  logic              wb_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(.MASTERS(M), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_we(m_we), .i_m_sel(m_sel),
    .i_m_stb(m_stb), .i_m_cyc(m_cyc),
    .o_m_dat(o_m_dat), .o_m_ack(o_m_ack), .o_m_err(o_m_err),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .o_wb_stb(o_wb_stb), .o_wb_cyc(o_wb_cyc),
    .i_wb_dat(wb_dat), .i_wb_ack(wb_ack),
    .o_grant(o_grant)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = bus idle), round-robin pointer, lockouts, stall count.
  int           owner, last, tmo;
  logic [M-1:0] lock;

  always @(posedge clk or negedge rst_n) begin
    logic [M-1:0] fire_v;
    bit           f;
    int           c;
    if (!rst_n) begin
      owner = -1;
      last  = M - 1;
      tmo   = 0;
      lock  = '0;
    end else begin
      fire_v = '0;
      if (owner < 0) begin
        for (int k = 1; k <= M; k++) begin
          c = (last + k) % M;
          if (m_cyc[c] && !lock[c]) begin
            owner = c;
            last  = c;
            tmo   = 0;
            break;
          end
        end
      end else begin
        f = TMO_EN && m_stb[owner] && !wb_ack && (tmo == T - 1);
        if (f) fire_v[owner] = 1'b1;
        if (!m_cyc[owner] || f) owner = -1;
        else if (wb_ack) tmo = 0;
        else if (m_stb[owner]) tmo = tmo + 1;
      end
      lock = (lock | fire_v) & m_cyc;
    end
  end

  always @(negedge clk) begin
    logic [M-1:0] eg, ea, ee;
    logic [31:0]  eadr, edat;
    logic         ewe, estb, ecyc;
    logic [3:0]   esel;
    if (rst_n) begin
      eg = '0; ea = '0; ee = '0;
      eadr = '0; edat = '0; ewe = 1'b0; estb = 1'b0; ecyc = 1'b0; esel = '0;
      if (owner >= 0) begin
        eg[owner] = 1'b1;
        ea[owner] = wb_ack;
        ee[owner] = TMO_EN && m_stb[owner] && !wb_ack && (tmo == T - 1);
        eadr = m_adr[owner]; edat = m_dat[owner]; ewe = m_we[owner];
        esel = m_sel[owner]; estb = m_stb[owner]; ecyc = m_cyc[owner];
      end
      chk("grant",  32'(o_grant),  32'(eg));
      chk("m_ack",  32'(o_m_ack),  32'(ea));
      chk("m_err",  32'(o_m_err),  32'(ee));
      chk("m_dat",  o_m_dat,       wb_dat);
      chk("wb_adr", o_wb_adr,      eadr);
      chk("wb_dat", o_wb_dat,      edat);
      chk("wb_ctl", 32'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}),
                    32'({ecyc, estb, ewe, esel}));
    end
  end

  task step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int g, output int idle);
    g = -1;
    idle = 0;
    for (int n = 0; n < 20; n++) begin
      if (o_grant != '0) begin
        for (int i = 0; i < M; i++) if (o_grant[i]) g = i;
        break;
      end
      idle++;
      step();
    end
    if (g < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_grant: no grant within 20 cycles at %0t", $time);
    end
  endtask

  task clear_inputs();
    m_adr = '0; m_dat = '0; m_we = '0; m_sel = '0; m_stb = '0; m_cyc = '0;
    wb_dat = '0; wb_ack = 1'b0;
  endtask

  int g, idle;
  int exp_seq [3] = '{0, 1, 0};

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_grant",  32'(o_grant), 32'h0);
    chk("rst_wb_cyc", 32'(o_wb_cyc), 32'h0);
    chk("rst_m_ack",  32'(o_m_ack), 32'h0);
    chk("rst_m_err",  32'(o_m_err), 32'h0);
    rst_n = 1'b1;

    // Single read by m0; slave answers two cycles after the request.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h1000_0004;
    #1 chk("t1_cyc_req_cycle", 32'(o_wb_cyc), 32'h0);
    step();
    chk("t1_cyc_next", 32'(o_wb_cyc), 32'h1);
    chk("t1_grant", 32'(o_grant), 32'h1);
    chk("t1_adr", o_wb_adr, 32'h1000_0004);
    step();
    wb_ack = 1'b1; wb_dat = 32'hCAFE_F00D;
    #1 chk("t1_ack", 32'(o_m_ack), 32'h1);
    chk("t1_rdata", o_m_dat, 32'hCAFE_F00D);
    step();
    clear_inputs();
    step();
    step();

    // m0 and m1 contend together: grants alternate with an idle gap.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11;
    for (int r = 0; r < 3; r++) begin
      wait_grant(g, idle);
      chk("t2_owner", 32'(g), 32'(exp_seq[r]));
      chk("t2_gap", 32'(idle >= 1), 32'h1);
      step();
      if (g >= 0) begin
        m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
        step();
        m_cyc[g] = 1'b1; m_stb[g] = 1'b1;
      end
    end
    clear_inputs();
    step();
    step();

    // m1 keeps the bus for 4 back-to-back writes while m0 waits.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_sel[1] = 4'b0011;
    m_adr[1] = 32'h2000_0000;
    step();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    wait_grant(g, idle);
    chk("t3_owner", 32'(g), 32'h1);
    wb_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_dat[1] = 32'(k) + 32'h55;
      #1 chk("t3_ack", 32'(o_m_ack), 32'h2);
      chk("t3_sel", 32'(o_wb_sel), 32'h3);
      chk("t3_wdat", o_wb_dat, 32'(k) + 32'h55);
      step();
    end
    wb_ack = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    chk("t3_idle_gap", 32'(o_grant), 32'h0);
    wait_grant(g, idle);
    chk("t3_m0_after", 32'(g), 32'h0);

    // Owner m0 drops CYC on the same edge m1 raises it; ack in IDLE is dropped.
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    wb_ack = 1'b1;
    #1 chk("t4_idle_grant", 32'(o_grant), 32'h0);
    chk("t4_no_ack", 32'(o_m_ack), 32'h0);
    step();
    wb_ack = 1'b0;
    chk("t4_grant_m1", 32'(o_grant), 32'h2);

    // Reset mid-burst: outputs drop immediately.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("t6_cyc", 32'(o_wb_cyc), 32'h0);
    chk("t6_stb", 32'(o_wb_stb), 32'h0);
    chk("t6_grant", 32'(o_grant), 32'h0);
    chk("t6_adr", o_wb_adr, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    wait_grant(g, idle);
    chk("t6_first_m0", 32'(g), 32'h0);

    // m0 stalls with no ack while m1 waits.
    for (int n = 0; n < T - 1; n++) begin
      chk("t5_no_err", 32'(o_m_err), 32'h0);
      step();
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("t5_err_pulse", 32'(o_m_err), 32'h1);
    step();
    chk("t5_cyc_drop", 32'(o_wb_cyc), 32'h0);
    chk("t5_err_gone", 32'(o_m_err), 32'h0);
    step();
    chk("t5_grant_m1", 32'(o_grant), 32'h2);
`else
    repeat (5) step();
    chk("t5_hung_hold", 32'(o_grant), 32'h1);
    chk("t5_err_tied", 32'(o_m_err), 32'h0);
`endif
    clear_inputs();
    step();

    // Random traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < M; i++) begin
        if (!m_cyc[i]) begin
          if ($urandom_range(99) < 25) begin
            m_cyc[i] = 1'b1;
            m_stb[i] = 1'b1;
          end
        end else if ($urandom_range(99) < 15) begin
          m_cyc[i] = 1'b0;
          m_stb[i] = 1'b0;
        end else begin
          m_stb[i] = ($urandom_range(99) < 80);
        end
        m_adr[i] = $urandom;
        m_dat[i] = $urandom;
        m_we[i]  = 1'($urandom_range(1));
        m_sel[i] = 4'($urandom_range(15));
      end
      wb_ack = 1'($urandom_range(1));
      wb_dat = $urandom;
      step();
    end
    clear_inputs();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
